video_reg_bank: RTL and testbench

Parametrised successor to the video controller's flat control-register array. It provides a shadow/active register set with frame-synchronous commit, a palette RAM of configurable depth, registered read-back and a vblank interrupt. It sits between the CPU register bus and the video timing/pixel pipeline. Software can reprogram the viewport and mode mid-frame without tearing.

---
 rtl/video_reg_bank.sv | 180 ++++++++++++++++++
 tb/tb_video_reg_bank.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_reg_bank.sv
// Video controller register bank: shadowed viewport/mode registers committed on
// vblank, palette RAM with combinational lookup, registered read-back and vblank irq.
module video_reg_bank #(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned PAL_ENTRIES = 16,
  parameter int unsigned PAL_W       = 12,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned PIDX_W     = (PAL_ENTRIES > 1) ? $clog2(PAL_ENTRIES) : 1
) (
  input  logic              reg_clk,
  input  logic              nreset,
  input  logic              reg_wr,
  input  logic              reg_rd,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_wdata,
  output logic [DATA_W-1:0] reg_rdata,
  output logic              reg_rvalid,
  input  logic              vblank_in,
  output logic              irq,
  output logic [15:0]       cfg_base,
  output logic [9:0]        cfg_left,
  output logic [9:0]        cfg_right,
  output logic [9:0]        cfg_top,
  output logic [9:0]        cfg_bottom,
  output logic [5:0]        cfg_mode,
  input  logic [PIDX_W-1:0] pal_idx,
  output logic [PAL_W-1:0]  pal_rgb
);

  localparam logic [2:0] SEL_STATUS = 3'd6;
  localparam logic [2:0] SEL_CTRL   = 3'd7;

  typedef struct packed {
    logic [15:0] base;
    logic [9:0]  left;
    logic [9:0]  right;
    logic [9:0]  top;
    logic [9:0]  bottom;
    logic [5:0]  mode;
  } view_t;

  view_t                  shadow_q, active_q, shadow_d, active_d;
  logic                   latch_en_q, irq_en_q, latch_en_d, irq_en_d;
  logic                   pending_q, pending_d;
  logic                   irq_flag_q, irq_flag_d;
  logic                   irq_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   vb_prev_q;
  logic [DATA_W-1:0]      rdata_q;
  logic                   rvalid_q;
  logic [PAL_W-1:0]       pal_mem [PAL_ENTRIES];

  logic                   reg_space_c, pal_hit_c, shadow_wr_c, commit_c;
  logic                   vb_sync_c, vb_rise_c;
  logic [2:0]             reg_sel_c;
  logic [PIDX_W-1:0]      pal_addr_c;
  logic [DATA_W-1:0]      rd_mux_c;

  // Apply a register-bus write to one field of a view; unused upper bits drop.
  function automatic view_t write_field(input view_t v, input logic [2:0] sel,
                                        input logic [DATA_W-1:0] d);
    view_t r;
    r = v;
    case (sel)
      3'd0:    r.base   = d[15:0];
      3'd1:    r.left   = d[9:0];
      3'd2:    r.right  = d[9:0];
      3'd3:    r.top    = d[9:0];
      3'd4:    r.bottom = d[9:0];
      3'd5:    r.mode   = d[5:0];
      default: r = v;
    endcase
    return r;
  endfunction

  // Address decode and vblank edge detect
  always_comb begin
    reg_space_c = (reg_addr[ADDR_W-1:3] == '0);
    reg_sel_c   = reg_addr[2:0];
    pal_hit_c   = reg_addr[ADDR_W-1] && (32'(reg_addr[ADDR_W-2:0]) < PAL_ENTRIES);
    pal_addr_c  = reg_addr[PIDX_W-1:0];
    shadow_wr_c = reg_wr && reg_space_c && (reg_sel_c <= 3'd5);
    vb_sync_c   = sync_q[SYNC_STAGES-1];
    vb_rise_c   = vb_sync_c && !vb_prev_q;
  end

  // Next-state for shadow/active views, control and interrupt flag
  always_comb begin
    shadow_d   = shadow_q;
    active_d   = active_q;
    pending_d  = pending_q;
    latch_en_d = latch_en_q;
    irq_en_d   = irq_en_q;
    irq_flag_d = irq_flag_q;
    commit_c   = pending_q && (vb_rise_c ||
                 (reg_wr && reg_space_c && reg_sel_c == SEL_CTRL && !reg_wdata[0]));

    // Commit uses the pre-write shadow; a same-cycle latched write re-arms pending.
    if (commit_c) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (shadow_wr_c) begin
      shadow_d = write_field(shadow_q, reg_sel_c, reg_wdata);
      if (latch_en_q) pending_d = 1'b1;
      else            active_d  = write_field(active_d, reg_sel_c, reg_wdata);
    end
    if (reg_wr && reg_space_c && reg_sel_c == SEL_CTRL) begin
      latch_en_d = reg_wdata[0];
      irq_en_d   = reg_wdata[1];
    end
    if (vb_rise_c) irq_flag_d = 1'b1;
    else if (reg_wr && reg_space_c && reg_sel_c == SEL_STATUS && reg_wdata[2]) irq_flag_d = 1'b0;
  end

  // Read-back mux; shadowed registers return the shadow copy
  always_comb begin
    rd_mux_c = '0;
    if (reg_space_c) begin
      case (reg_sel_c)
        3'd0:       rd_mux_c = DATA_W'(shadow_q.base);
        3'd1:       rd_mux_c = DATA_W'(shadow_q.left);
        3'd2:       rd_mux_c = DATA_W'(shadow_q.right);
        3'd3:       rd_mux_c = DATA_W'(shadow_q.top);
        3'd4:       rd_mux_c = DATA_W'(shadow_q.bottom);
        3'd5:       rd_mux_c = DATA_W'(shadow_q.mode);
        SEL_STATUS: rd_mux_c = DATA_W'({irq_flag_q, vb_sync_c, pending_q});
        default:    rd_mux_c = DATA_W'({irq_en_q, latch_en_q});
      endcase
    end else if (pal_hit_c) begin
      rd_mux_c = DATA_W'(pal_mem[pal_addr_c]);
    end
  end

  always_ff @(posedge reg_clk) begin
    if (!nreset) begin
      shadow_q   <= '0;
      active_q   <= '0;
      latch_en_q <= 1'b0;
      irq_en_q   <= 1'b0;
      pending_q  <= 1'b0;
      irq_flag_q <= 1'b0;
      irq_q      <= 1'b0;
      sync_q     <= '0;
      vb_prev_q  <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      latch_en_q <= latch_en_d;
      irq_en_q   <= irq_en_d;
      pending_q  <= pending_d;
      irq_flag_q <= irq_flag_d;
      irq_q      <= irq_flag_q && irq_en_q;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], vblank_in};
      vb_prev_q  <= vb_sync_c;
      rvalid_q   <= reg_rd;
      if (reg_rd) rdata_q <= rd_mux_c;
    end
  end

  // Palette storage is not reset; writes take effect immediately
  always_ff @(posedge reg_clk) begin
    if (nreset && reg_wr && pal_hit_c) pal_mem[pal_addr_c] <= reg_wdata[PAL_W-1:0];
  end

  assign reg_rdata  = rdata_q;
  assign reg_rvalid = rvalid_q;
  assign irq        = irq_q;
  assign cfg_base   = active_q.base;
  assign cfg_left   = active_q.left;
  assign cfg_right  = active_q.right;
  assign cfg_top    = active_q.top;
  assign cfg_bottom = active_q.bottom;
  assign cfg_mode   = active_q.mode;
  assign pal_rgb    = pal_mem[pal_idx];

endmodule

// File: tb/tb_video_reg_bank.sv
// Bench for video_reg_bank: directed scenarios plus a randomized run, all checked
// against an array-based reference model stepped once per clock edge.
module tb_video_reg_bank;
  localparam int S = 2;

  logic        reg_clk = 1'b0;
  logic        nreset, reg_wr, reg_rd, reg_rvalid, vblank_in, irq;
  logic [5:0]  reg_addr;
  logic [15:0] reg_wdata, reg_rdata, cfg_base;
  logic [9:0]  cfg_left, cfg_right, cfg_top, cfg_bottom;
  logic [5:0]  cfg_mode;
  logic [3:0]  pal_idx;
  logic [11:0] pal_rgb;
  logic [61:0] dut_cfg;
  int          total = 0;
  int          bad = 0;

  video_reg_bank dut (
    .reg_clk(reg_clk), .nreset(nreset), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .reg_rvalid(reg_rvalid), .vblank_in(vblank_in), .irq(irq),
    .cfg_base(cfg_base), .cfg_left(cfg_left), .cfg_right(cfg_right),
    .cfg_top(cfg_top), .cfg_bottom(cfg_bottom), .cfg_mode(cfg_mode),
    .pal_idx(pal_idx), .pal_rgb(pal_rgb)
  );

  assign dut_cfg = {cfg_base, cfg_left, cfg_right, cfg_top, cfg_bottom, cfg_mode};

  always #5 reg_clk = ~reg_clk;

  // Reference model state
  logic [15:0] m_sh[6];
  logic [15:0] m_ac[6];
  logic [11:0] m_pal[16];
  logic        m_hist[S+1];
  logic        m_latch, m_irqen, m_pend, m_flag, m_irq, m_rvalid;
  logic [15:0] m_rdata;

  function automatic logic [15:0] fmask(input int i);
    if (i == 0) return 16'hFFFF;
    if (i == 5) return 16'h003F;
    return 16'h03FF;
  endfunction

  function automatic logic [61:0] m_cfg();
    return {m_ac[0], m_ac[1][9:0], m_ac[2][9:0], m_ac[3][9:0], m_ac[4][9:0], m_ac[5][5:0]};
  endfunction

  function automatic logic [15:0] m_read(input logic [5:0] a);
    int ai;
    ai = int'(a);
    if (ai < 6) return m_sh[ai];
    if (ai == 6) return {13'd0, m_flag, m_hist[S-1], m_pend};
    if (ai == 7) return {14'd0, m_irqen, m_latch};
    if (ai >= 32 && ai < 48) return {4'd0, m_pal[ai-32]};
    return 16'd0;
  endfunction

  // One clock edge of the register-bank behaviour
  task automatic model_edge(input logic rstn, input logic wr, input logic rd,
                            input logic [5:0] a, input logic [15:0] d, input logic vin);
    logic        rise, commit, npend;
    logic [15:0] nsh[6];
    logic [15:0] nac[6];
    int          ai;
    ai = int'(a);
    if (!rstn) begin
      for (int i = 0; i < 6; i++) begin m_sh[i] = 16'd0; m_ac[i] = 16'd0; end
      for (int i = 0; i <= S; i++) m_hist[i] = 1'b0;
      m_latch = 0; m_irqen = 0; m_pend = 0; m_flag = 0; m_irq = 0;
      m_rvalid = 0; m_rdata = 16'd0;
      return;
    end
    rise = m_hist[S-1] && !m_hist[S];
    m_rvalid = rd;
    if (rd) m_rdata = m_read(a);
    m_irq = m_flag && m_irqen;
    commit = m_pend && (rise || (wr && ai == 7 && !d[0]));
    nsh = m_sh; nac = m_ac; npend = m_pend;
    if (commit) begin nac = m_sh; npend = 1'b0; end
    if (wr && ai < 6) begin
      nsh[ai] = d & fmask(ai);
      if (m_latch) npend = 1'b1;
      else nac[ai] = d & fmask(ai);
    end
    if (wr && ai == 7) begin m_latch = d[0]; m_irqen = d[1]; end
    if (rise) m_flag = 1'b1;
    else if (wr && ai == 6 && d[2]) m_flag = 1'b0;
    if (wr && ai >= 32 && ai < 48) m_pal[ai-32] = d[11:0];
    m_sh = nsh; m_ac = nac; m_pend = npend;
    for (int i = S; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = vin;
  endtask

  task automatic tick(input logic wr, input logic rd, input logic [5:0] a, input logic [15:0] d);
    logic rstn, vin;
    reg_wr = wr; reg_rd = rd; reg_addr = a; reg_wdata = d;
    rstn = nreset; vin = vblank_in;
    @(posedge reg_clk);
    model_edge(rstn, wr, rd, a, d, vin);
    #1;
    reg_wr = 1'b0; reg_rd = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 6'd0, 16'd0);
  endtask

  task automatic test_reset();
    nreset = 1'b0; vblank_in = 1'b0;
    idle(2);
    total++; if (dut_cfg !== 62'd0) begin bad++; $display("FAIL reset_cfg got=%h exp=0", dut_cfg); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    total++; if (reg_rvalid !== 1'b0 || reg_rdata !== 16'd0) begin bad++;
      $display("FAIL reset_rd got=%b/%h exp=0/0000", reg_rvalid, reg_rdata); end
    nreset = 1'b1;
    idle(1);
    tick(1'b0, 1'b1, 6'd6, 16'd0);
    total++; if (reg_rdata !== 16'd0) begin bad++; $display("FAIL reset_status got=%h exp=0000", reg_rdata); end
  endtask

  task automatic test_direct_write();
    tick(1'b1, 1'b0, 6'd0, 16'h1234);
    total++; if (cfg_base !== 16'h1234) begin bad++; $display("FAIL direct_base got=%h exp=1234", cfg_base); end
    tick(1'b0, 1'b1, 6'd0, 16'd0);
    total++; if (reg_rvalid !== 1'b1 || reg_rdata !== 16'h1234) begin bad++;
      $display("FAIL direct_read got=%b/%h exp=1/1234", reg_rvalid, reg_rdata); end
    idle(1);
    total++; if (reg_rvalid !== 1'b0 || reg_rdata !== 16'h1234) begin bad++;
      $display("FAIL rdata_hold got=%b/%h exp=0/1234", reg_rvalid, reg_rdata); end
    tick(1'b1, 1'b0, 6'd5, 16'hFFFF);
    total++; if (cfg_mode !== 6'h3F) begin bad++; $display("FAIL mode_trunc got=%h exp=3f", cfg_mode); end
    tick(1'b0, 1'b1, 6'd5, 16'd0);
    total++; if (reg_rdata !== 16'h003F) begin bad++; $display("FAIL mode_readback got=%h exp=003f", reg_rdata); end
  endtask

  task automatic test_latched();
    logic found;
    tick(1'b1, 1'b0, 6'd7, 16'h0001);
    tick(1'b1, 1'b0, 6'd1, 16'h02C0);
    total++; if (cfg_left !== 10'h000) begin bad++; $display("FAIL latch_hold got=%h exp=000", cfg_left); end
    tick(1'b0, 1'b1, 6'd6, 16'd0);
    total++; if (reg_rdata[0] !== 1'b1) begin bad++; $display("FAIL pending_set got=%b exp=1", reg_rdata[0]); end
    vblank_in = 1'b1;
    idle(S);
    total++; if (cfg_left !== 10'h000) begin bad++; $display("FAIL commit_early got=%h exp=000", cfg_left); end
    found = 1'b0;
    for (int i = 0; i < 2 && !found; i++) begin
      idle(1);
      if (cfg_left === 10'h2C0) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL commit_timeout got=%h exp=2c0", cfg_left); end
    tick(1'b0, 1'b1, 6'd6, 16'd0);
    total++; if (reg_rdata[0] !== 1'b0) begin bad++; $display("FAIL pending_clear got=%b exp=0", reg_rdata[0]); end
    vblank_in = 1'b0;
    idle(S + 2);
  endtask

  task automatic test_coincident();
    tick(1'b1, 1'b0, 6'd3, 16'd5);
    vblank_in = 1'b1;
    idle(S);
    tick(1'b1, 1'b0, 6'd3, 16'd7);
    total++; if (cfg_top !== 10'd5) begin bad++; $display("FAIL coinc_first got=%h exp=005", cfg_top); end
    tick(1'b0, 1'b1, 6'd6, 16'd0);
    total++; if (reg_rdata[0] !== 1'b1) begin bad++; $display("FAIL coinc_pending got=%b exp=1", reg_rdata[0]); end
    vblank_in = 1'b0;
    idle(S + 2);
    vblank_in = 1'b1;
    idle(S + 1);
    total++; if (cfg_top !== 10'd7) begin bad++; $display("FAIL coinc_second got=%h exp=007", cfg_top); end
    vblank_in = 1'b0;
    idle(S + 2);
  endtask

  task automatic test_irq();
    logic found;
    tick(1'b1, 1'b0, 6'd7, 16'h0002);
    tick(1'b1, 1'b0, 6'd6, 16'h0004);
    idle(2);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_idle got=%b exp=0", irq); end
    vblank_in = 1'b1;
    found = 1'b0;
    for (int i = 0; i < S + 3 && !found; i++) begin
      idle(1);
      if (irq === 1'b1) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL irq_rise_timeout got=%b exp=1", irq); end
    tick(1'b1, 1'b0, 6'd6, 16'h0004);
    idle(1);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear got=%b exp=0", irq); end
    vblank_in = 1'b0;
    idle(S + 2);
    vblank_in = 1'b1;
    idle(S);
    tick(1'b1, 1'b0, 6'd6, 16'h0004);
    idle(1);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_set_wins got=%b exp=1", irq); end
    tick(1'b0, 1'b1, 6'd6, 16'd0);
    total++; if (reg_rdata[2:1] !== 2'b11) begin bad++; $display("FAIL status_flag got=%b exp=11", reg_rdata[2:1]); end
    vblank_in = 1'b0;
    idle(S + 2);
  endtask

  task automatic test_palette();
    for (int i = 0; i < 16; i++) tick(1'b1, 1'b0, 6'(32 + i), 16'($urandom));
    tick(1'b1, 1'b0, 6'h23, 16'hFABC);
    pal_idx = 4'd3;
    #1;
    total++; if (pal_rgb !== 12'hABC) begin bad++; $display("FAIL pal_lookup got=%h exp=abc", pal_rgb); end
    tick(1'b0, 1'b1, 6'h23, 16'd0);
    total++; if (reg_rdata !== 16'h0ABC) begin bad++; $display("FAIL pal_readback got=%h exp=0abc", reg_rdata); end
    tick(1'b1, 1'b0, 6'h0C, 16'hFFFF);
    tick(1'b0, 1'b1, 6'h0C, 16'd0);
    total++; if (reg_rdata !== 16'd0) begin bad++; $display("FAIL unmapped_low got=%h exp=0000", reg_rdata); end
    tick(1'b1, 1'b0, 6'h3F, 16'h1111);
    tick(1'b0, 1'b1, 6'h3F, 16'd0);
    total++; if (reg_rdata !== 16'd0) begin bad++; $display("FAIL unmapped_pal got=%h exp=0000", reg_rdata); end
  endtask

  task automatic test_back_to_back();
    tick(1'b1, 1'b0, 6'd7, 16'h0000);
    tick(1'b1, 1'b0, 6'd0, 16'hAAAA);
    tick(1'b1, 1'b1, 6'd0, 16'h5555);
    total++; if (reg_rdata !== 16'hAAAA || cfg_base !== 16'h5555) begin bad++;
      $display("FAIL rw_same got=%h/%h exp=aaaa/5555", reg_rdata, cfg_base); end
    tick(1'b1, 1'b0, 6'd2, 16'h0123);
    tick(1'b0, 1'b1, 6'd2, 16'd0);
    tick(1'b0, 1'b1, 6'd0, 16'd0);
    total++; if (reg_rvalid !== 1'b1 || reg_rdata !== 16'h5555) begin bad++;
      $display("FAIL b2b_read got=%b/%h exp=1/5555", reg_rvalid, reg_rdata); end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 1'b0, 6'd7, 16'h0003);
    vblank_in = 1'b1;
    idle(S + 2);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL pre_reset_irq got=%b exp=1", irq); end
    vblank_in = 1'b0;
    idle(S + 1);
    tick(1'b1, 1'b0, 6'd0, 16'h0055);
    nreset = 1'b0;
    idle(1);
    total++; if (dut_cfg !== 62'd0 || irq !== 1'b0) begin bad++;
      $display("FAIL mid_reset got=%h/%b exp=0/0", dut_cfg, irq); end
    nreset = 1'b1;
    tick(1'b0, 1'b1, 6'd6, 16'd0);
    total++; if (reg_rdata !== 16'd0) begin bad++; $display("FAIL mid_reset_status got=%h exp=0000", reg_rdata); end
    vblank_in = 1'b1;
    nreset = 1'b0;
    idle(1);
    nreset = 1'b1;
    idle(S + 2);
    tick(1'b0, 1'b1, 6'd6, 16'd0);
    total++; if (reg_rdata[2] !== 1'b1) begin bad++; $display("FAIL post_reset_rise got=%b exp=1", reg_rdata[2]); end
    vblank_in = 1'b0;
    idle(S + 2);
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      logic        wr, rd;
      logic [5:0]  a;
      logic [15:0] d;
      int          sel;
      if ($urandom_range(0, 29) == 0) vblank_in = ~vblank_in;
      nreset = ($urandom_range(0, 599) != 0);
      sel = int'($urandom_range(0, 9));
      if (sel < 8) a = 6'(sel);
      else if (sel == 8) a = 6'(32 + $urandom_range(0, 15));
      else a = 6'($urandom_range(0, 63));
      wr = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 1) == 0);
      d = 16'($urandom);
      pal_idx = 4'($urandom_range(0, 15));
      tick(wr, rd, a, d);
      total++; if (dut_cfg !== m_cfg()) begin bad++;
        $display("FAIL rand_cfg n=%0d got=%h exp=%h", n, dut_cfg, m_cfg()); end
      total++; if (reg_rvalid !== m_rvalid || reg_rdata !== m_rdata) begin bad++;
        $display("FAIL rand_read n=%0d got=%b/%h exp=%b/%h", n, reg_rvalid, reg_rdata, m_rvalid, m_rdata); end
      total++; if (irq !== m_irq) begin bad++; $display("FAIL rand_irq n=%0d got=%b exp=%b", n, irq, m_irq); end
      total++; if (pal_rgb !== m_pal[pal_idx]) begin bad++;
        $display("FAIL rand_pal n=%0d got=%h exp=%h", n, pal_rgb, m_pal[pal_idx]); end
    end
    nreset = 1'b1;
  endtask

  initial begin
    nreset = 1'b0; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = 6'd0;
    reg_wdata = 16'd0; vblank_in = 1'b0; pal_idx = 4'd0;
    test_reset();
    test_direct_write();
    test_latched();
    test_coincident();
    test_irq();
    test_palette();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
